decode_stage: RTL and testbench

//  Registered RV32I/RV64I decode stage between fetch and register read. Splits each instruction into fields.

---
 rtl/decode_stage_pkg.sv | 56 +++++
 rtl/decode_stage_decoder_core.sv | 175 +++++++++++++++++
 rtl/decode_stage.sv | 155 +++++++++++++++
 tb/tb_decode_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I/RV64I decode stage.
package decode_stage_pkg;

  // Widest supported datapath; narrower builds truncate the immediate at use.
  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_INVALID = 3'd6
  } inst_format_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // Decoded bundle; imm is always held at MAX_XLEN and sign-extended to it.
  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    inst_format_e        fmt;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_decoder_core.sv
// Pure combinational RV32I/RV64I instruction decoder: raw word -> decoded_t.
module decoder_core
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RV_M = 0
) (
  input  logic [31:0] inst_i,
  output decoded_t    dec_o
);

  localparam bit RV64  = (XLEN == 64);
  localparam bit HAS_M = (RV_M != 0);

  logic [6:0]   opc;
  logic [2:0]   f3;
  logic [6:0]   f7;
  logic [4:0]   rd_field;
  inst_format_e fmt;
  logic         ill;
  logic         shift_imm;
  logic         no_rs1_rd;
  logic         sh32_ok;
  logic         sh64_ok;
  logic         op_f7_ok;
  logic         use_rs1;
  logic         use_rs2;
  logic         use_rd;
  logic [MAX_XLEN-1:0] imm;

  assign opc      = inst_i[6:0];
  assign f3       = inst_i[14:12];
  assign f7       = inst_i[31:25];
  assign rd_field = inst_i[11:7];

  // 5-bit shamt forms: only srai may set inst[30]; inst[25] is shamt[5] and illegal here.
  assign sh32_ok = (f3 == 3'b001) ? (f7 == 7'b0000000)
                                  : ((f7 == 7'b0000000) || (f7 == 7'b0100000));
  // 6-bit shamt form: inst[25] belongs to the shift amount.
  assign sh64_ok = (f3 == 3'b001) ? (inst_i[31:26] == 6'b000000)
                                  : ((inst_i[31:26] == 6'b000000) || (inst_i[31:26] == 6'b010000));
  assign op_f7_ok = (f7 == 7'b0000000)
                 || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))
                 || (HAS_M && (f7 == 7'b0000001));

  // Opcode classification: format, legality, shift-immediate and FENCE/SYSTEM marking.
  always_comb begin
    fmt       = FMT_INVALID;
    ill       = 1'b0;
    shift_imm = 1'b0;
    no_rs1_rd = 1'b0;
    case (opc)
      OPC_LOAD: begin
        fmt = FMT_I;
        ill = (f3 == 3'b111) || (!RV64 && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OPC_MISC_MEM: begin
        fmt       = FMT_I;
        no_rs1_rd = 1'b1;
        ill       = (f3 != 3'b000);
      end
      OPC_OP_IMM: begin
        fmt       = FMT_I;
        shift_imm = (f3 == 3'b001) || (f3 == 3'b101);
        if (shift_imm) ill = RV64 ? !sh64_ok : !sh32_ok;
      end
      OPC_AUIPC: fmt = FMT_U;
      OPC_OP_IMM_32: begin
        fmt       = FMT_I;
        shift_imm = (f3 == 3'b001) || (f3 == 3'b101);
        ill       = !RV64 || (shift_imm && !sh32_ok);
      end
      OPC_STORE: begin
        fmt = FMT_S;
        ill = f3[2] || (!RV64 && (f3 == 3'b011));
      end
      OPC_OP: begin
        fmt = FMT_R;
        ill = !op_f7_ok;
      end
      OPC_LUI: fmt = FMT_U;
      OPC_OP_32: begin
        fmt = FMT_R;
        ill = !RV64 || !op_f7_ok;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JALR: begin
        fmt = FMT_I;
        ill = (f3 != 3'b000);
      end
      OPC_JAL: fmt = FMT_J;
      OPC_SYSTEM: begin
        fmt       = FMT_I;
        no_rs1_rd = 1'b1;
        ill       = (inst_i != INST_ECALL) && (inst_i != INST_EBREAK);
      end
      default: begin
        fmt = FMT_INVALID;
        ill = 1'b1;
      end
    endcase
  end

  // Register usage and immediate assembly, both selected by format.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm     = '0;
    case (fmt)
      FMT_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      FMT_I: begin
        use_rs1 = !no_rs1_rd;
        use_rd  = !no_rs1_rd;
        imm     = {{(MAX_XLEN-12){inst_i[31]}}, inst_i[31:20]};
      end
      FMT_S: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{(MAX_XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      FMT_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{(MAX_XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                   inst_i[30:25], inst_i[11:8], 1'b0};
      end
      FMT_U: begin
        use_rd = 1'b1;
        imm    = {{(MAX_XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
      end
      FMT_J: begin
        use_rd = 1'b1;
        imm    = {{(MAX_XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm     = '0;
      end
    endcase
  end

  // Bundle assembly; illegal encodings keep their fields but claim no registers.
  always_comb begin
    dec_o           = '0;
    dec_o.imm       = imm;
    dec_o.opcode    = opc;
    dec_o.funct3    = f3;
    dec_o.fmt       = fmt;
    dec_o.illegal   = ill;
    dec_o.rs1       = use_rs1 ? inst_i[19:15] : 5'd0;
    dec_o.rs2       = use_rs2 ? inst_i[24:20] : 5'd0;
    dec_o.rd        = use_rd  ? rd_field      : 5'd0;
    dec_o.uses_rs1  = use_rs1 && !ill;
    dec_o.uses_rs2  = use_rs2 && !ill;
    dec_o.writes_rd = use_rd && (rd_field != 5'd0) && !ill;
    if (fmt == FMT_R) begin
      dec_o.funct7 = f7;
    end else if (shift_imm) begin
      // RV64 OP-IMM shifts reuse inst[25] as shamt[5], so it is masked out of funct7.
      dec_o.funct7 = (RV64 && (opc == OPC_OP_IMM)) ? {inst_i[31:26], 1'b0} : f7;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: elastic two-entry buffer around decoder_core with flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RV_M = 0,
  parameter int SKID = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output inst_format_e    format_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o,
  output logic            writes_rd_o,
  output logic            illegal_o
);

  localparam bit HAS_SKID = (SKID != 0);

  buf_state_e      state_q;
  buf_state_e      state_d;
  decoded_t        dec_in;
  decoded_t        out_dec_q;
  decoded_t        skid_dec_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] skid_pc_q;
  logic            accept;
  logic            load_out_in;
  logic            load_out_skid;
  logic            load_skid;

  decoder_core #(
    .XLEN (XLEN),
    .RV_M (RV_M)
  ) u_decoder_core (
    .inst_i (inst_i),
    .dec_o  (dec_in)
  );

  generate
    if (HAS_SKID) begin : g_ready_skid
      assign in_ready_o = (state_q != ST_FULL);
    end else begin : g_ready_pass
      assign in_ready_o = (state_q == ST_EMPTY) || out_ready_i;
    end
  endgenerate

  assign out_valid_o = (state_q != ST_EMPTY);
  // A flushed cycle never takes the incoming instruction.
  assign accept      = in_valid_i && in_ready_o && !flush_i;

  // Buffer occupancy register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Occupancy transitions and which register each transfer loads.
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && out_ready_i) begin
          load_out_in = 1'b1;
        end else if (accept && HAS_SKID) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_ready_i) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready_i) begin
          state_d       = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d       = ST_EMPTY;
      load_out_skid = 1'b0;
    end
  end

  // ---- output stage: cleared on reset so no stale bundle is ever visible ----
  // Output register: refilled from the decoder or promoted from the skid entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_dec_q <= '0;
      out_pc_q  <= '0;
    end else if (load_out_in) begin
      out_dec_q <= dec_in;
      out_pc_q  <= pc_i;
    end else if (load_out_skid) begin
      out_dec_q <= skid_dec_q;
      out_pc_q  <= skid_pc_q;
    end
  end

  // ---- skid stage: only meaningful while the buffer is FULL ----
  // Skid register catches the instruction accepted while the output is stalled.
  always_ff @(posedge clk_i) begin
    if (load_skid) begin
      skid_dec_q <= dec_in;
      skid_pc_q  <= pc_i;
    end
  end

  generate
    if (XLEN < MAX_XLEN) begin : g_imm_trunc
      logic unused_imm_hi;
      assign unused_imm_hi = ^out_dec_q.imm[MAX_XLEN-1:XLEN];
    end
  endgenerate

  assign pc_o        = out_pc_q;
  assign opcode_o    = out_dec_q.opcode;
  assign funct3_o    = out_dec_q.funct3;
  assign funct7_o    = out_dec_q.funct7;
  assign rs1_o       = out_dec_q.rs1;
  assign rs2_o       = out_dec_q.rs2;
  assign rd_o        = out_dec_q.rd;
  assign imm_o       = out_dec_q.imm[XLEN-1:0];
  assign format_o    = out_dec_q.fmt;
  assign uses_rs1_o  = out_dec_q.uses_rs1;
  assign uses_rs2_o  = out_dec_q.uses_rs2;
  assign writes_rd_o = out_dec_q.writes_rd;
  assign illegal_o   = out_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: an RV32 (RV_M=0) and an RV64 (RV_M=1) stage share one input stream.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;
  logic [63:0] pcv = 64'h100;

  logic         in_ready32, ov32, u1_32, u2_32, wr32, ill32;
  logic [31:0]  pc32, imm32;
  logic [6:0]   op32, f7_32;
  logic [2:0]   f3_32;
  logic [4:0]   rs1_32, rs2_32, rd32;
  inst_format_e fmt32;

  logic         in_ready64, ov64, u1_64, u2_64, wr64, ill64;
  logic [63:0]  pc64, imm64;
  logic [6:0]   op64, f7_64;
  logic [2:0]   f3_64;
  logic [4:0]   rs1_64, rs2_64, rd64;
  inst_format_e fmt64;

  int   errors = 0;
  int   checks = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t mon_e32, mon_e64, act32, act64;
  logic [31:0] stall_pc;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RV_M(0), .SKID(1)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .inst_i(inst), .pc_i(pc[31:0]), .out_valid_o(ov32), .out_ready_i(out_ready), .pc_o(pc32),
    .opcode_o(op32), .funct3_o(f3_32), .funct7_o(f7_32), .rs1_o(rs1_32), .rs2_o(rs2_32),
    .rd_o(rd32), .imm_o(imm32), .format_o(fmt32), .uses_rs1_o(u1_32), .uses_rs2_o(u2_32),
    .writes_rd_o(wr32), .illegal_o(ill32)
  );

  decode_stage #(.XLEN(64), .RV_M(1), .SKID(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .inst_i(inst), .pc_i(pc), .out_valid_o(ov64), .out_ready_i(out_ready), .pc_o(pc64),
    .opcode_o(op64), .funct3_o(f3_64), .funct7_o(f7_64), .rs1_o(rs1_64), .rs2_o(rs2_64),
    .rd_o(rd64), .imm_o(imm64), .format_o(fmt64), .uses_rs1_o(u1_64), .uses_rs2_o(u2_64),
    .writes_rd_o(wr64), .illegal_o(ill64)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // flags = {uses_rs1, uses_rs2, writes_rd, illegal}
  function automatic exp_t mk(input logic [31:0] w, input logic [6:0] f7, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                              input inst_format_e f, input logic [3:0] flags);
    exp_t e;
    e        = '0;
    e.imm    = imm;
    e.opcode = w[6:0];
    e.funct3 = w[14:12];
    e.funct7 = f7;
    e.rs1    = rs1;
    e.rs2    = rs2;
    e.rd     = rd;
    e.fmt    = f;
    {e.u1, e.u2, e.wr, e.ill} = flags;
    return e;
  endfunction

  // Offer one instruction; push expectations when the (registered) ready says it will be taken.
  task automatic send(input logic [31:0] w, input exp_t e32, input exp_t e64);
    int n;
    n        = 0;
    in_valid = 1'b1;
    inst     = w;
    pc       = pcv;
    while (!in_ready32 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept ready", in_ready32, 1'b1);
    if (in_ready32) begin
      e32.pc = {32'b0, pcv[31:0]};
      e64.pc = pcv;
      q32.push_back(e32);
      q64.push_back(e64);
    end
    pcv = pcv + 64'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {q32.size(), q64.size(), 30'b0, ov32, ov64}, 0);
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        q32.delete();
        q64.delete();
      end else begin
        if (ov32 && out_ready) begin
          act32 = {{32'b0, pc32}, {32'b0, imm32}, op32, f3_32, f7_32, rs1_32, rs2_32, rd32,
                   fmt32, u1_32, u2_32, wr32, ill32};
          if (q32.size() == 0) chk("rv32 unexpected output", act32, 0);
          else begin
            mon_e32 = q32.pop_front();
            chk("rv32 bundle", act32, mon_e32);
          end
        end
        if (ov64 && out_ready) begin
          act64 = {pc64, imm64, op64, f3_64, f7_64, rs1_64, rs2_64, rd64,
                   fmt64, u1_64, u2_64, wr64, ill64};
          if (q64.size() == 0) chk("rv64 unexpected output", act64, 0);
          else begin
            mon_e64 = q64.pop_front();
            chk("rv64 bundle", act64, mon_e64);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid/ready", {ov32, ov64, in_ready32, in_ready64}, 4'b0011);
    chk("reset data32", {pc32, imm32, op32, rd32, ill32}, 0);
    chk("reset data64", {pc64, imm64, op64, rd64, ill64}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    send(32'hFFF10093, mk(32'hFFF10093, 7'd0, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF, FMT_I, 4'b1010),
                       mk(32'hFFF10093, 7'd0, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 4'b1010));
    chk("one-cycle latency", {ov32, ov64}, 2'b11);
    send(32'h4210D093, mk(32'h4210D093, 7'b0100001, 5'd1, 5'd0, 5'd1, 64'h421, FMT_I, 4'b0001),
                       mk(32'h4210D093, 7'b0100000, 5'd1, 5'd0, 5'd1, 64'h421, FMT_I, 4'b1010));
    send(32'h022081B3, mk(32'h022081B3, 7'b0000001, 5'd1, 5'd2, 5'd3, 64'h0, FMT_R, 4'b0001),
                       mk(32'h022081B3, 7'b0000001, 5'd1, 5'd2, 5'd3, 64'h0, FMT_R, 4'b1110));
    send(32'h800002B7, mk(32'h800002B7, 7'd0, 5'd0, 5'd0, 5'd5, 64'h8000_0000, FMT_U, 4'b0010),
                       mk(32'h800002B7, 7'd0, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_8000_0000, FMT_U, 4'b0010));
    send(32'h00000001, mk(32'h00000001, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_INVALID, 4'b0001),
                       mk(32'h00000001, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_INVALID, 4'b0001));
    send(32'h00013083, mk(32'h00013083, 7'd0, 5'd2, 5'd0, 5'd1, 64'h0, FMT_I, 4'b0001),
                       mk(32'h00013083, 7'd0, 5'd2, 5'd0, 5'd1, 64'h0, FMT_I, 4'b1010));
    send(32'h00000013, mk(32'h00000013, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b1000),
                       mk(32'h00000013, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b1000));
    send(32'h00000073, mk(32'h00000073, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b0000),
                       mk(32'h00000073, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b0000));
    drain("stream drained");

    // Back-pressure: two accepts fill the buffer, third waits, order preserved.
    out_ready = 1'b0;
    stall_pc  = pcv[31:0];
    send(32'h0020A423, mk(32'h0020A423, 7'd0, 5'd1, 5'd2, 5'd0, 64'h8, FMT_S, 4'b1100),
                       mk(32'h0020A423, 7'd0, 5'd1, 5'd2, 5'd0, 64'h8, FMT_S, 4'b1100));
    send(32'hFE208EE3, mk(32'hFE208EE3, 7'd0, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFC, FMT_B, 4'b1100),
                       mk(32'hFE208EE3, 7'd0, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 4'b1100));
    chk("ready low when full", {in_ready32, in_ready64}, 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    chk("stalled output held", {ov32, pc32, imm32, in_ready32}, {1'b1, stall_pc, 32'h8, 1'b0});
    out_ready = 1'b1;
    send(32'h008000EF, mk(32'h008000EF, 7'd0, 5'd0, 5'd0, 5'd1, 64'h8, FMT_J, 4'b0010),
                       mk(32'h008000EF, 7'd0, 5'd0, 5'd0, 5'd1, 64'h8, FMT_J, 4'b0010));
    drain("stall drained");

    // Flush while full with a new instruction offered: nothing of it survives.
    out_ready = 1'b0;
    send(32'hFFF10093, mk(32'hFFF10093, 7'd0, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF, FMT_I, 4'b1010),
                       mk(32'hFFF10093, 7'd0, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 4'b1010));
    send(32'h800002B7, mk(32'h800002B7, 7'd0, 5'd0, 5'd0, 5'd5, 64'h8000_0000, FMT_U, 4'b0010),
                       mk(32'h800002B7, 7'd0, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_8000_0000, FMT_U, 4'b0010));
    in_valid = 1'b1;
    inst     = 32'h022081B3;
    pc       = 64'h0BAD;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush empties", {ov32, ov64}, 2'b00);
    chk("flush ready", {in_ready32, in_ready64}, 2'b11);
    out_ready = 1'b1;
    send(32'h00000013, mk(32'h00000013, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b1000),
                       mk(32'h00000013, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b1000));
    drain("flush drained");

    // Asynchronous reset while full: output drops without waiting for a clock edge.
    out_ready = 1'b0;
    send(32'h00000073, mk(32'h00000073, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b0000),
                       mk(32'h00000073, 7'd0, 5'd0, 5'd0, 5'd0, 64'h0, FMT_I, 4'b0000));
    send(32'h00013083, mk(32'h00013083, 7'd0, 5'd2, 5'd0, 5'd1, 64'h0, FMT_I, 4'b0001),
                       mk(32'h00013083, 7'd0, 5'd2, 5'd0, 5'd1, 64'h0, FMT_I, 4'b1010));
    #2;
    rst = 1'b1;
    #1;
    chk("async reset valid/ready", {ov32, ov64, in_ready32, in_ready64}, 4'b0011);
    chk("async reset data", {pc32, pc64, imm64}, 0);
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h008000EF, mk(32'h008000EF, 7'd0, 5'd0, 5'd0, 5'd1, 64'h8, FMT_J, 4'b0010),
                       mk(32'h008000EF, 7'd0, 5'd0, 5'd0, 5'd1, 64'h8, FMT_J, 4'b0010));
    drain("post-reset drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
